// File: rtl/gray_to_bin_dec.sv
`default_nettype none
// gray_to_bin_dec: two-stage valid/ready Gray-to-binary decoder, rev 1.0.
// Define GRAY_STEP_CHECK_EN to build the single-bit-step checker (out_err, err_cnt).
module gray_to_bin_dec #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] G,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] B,
  output logic             out_err,
  output logic [7:0]       err_cnt
);

  logic             s1_valid;
  logic [WIDTH-1:0] s1_g;
  logic [WIDTH-1:0] dec;
  logic             s2_free;
  logic             in_xfer;

  assign s2_free  = !out_valid || out_ready;
  assign in_ready = !s1_valid || s2_free;
  assign in_xfer  = in_valid && in_ready;

  // Each binary bit is the XOR of all Gray bits at or above it.
  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_dec
      assign dec[i] = ^s1_g[WIDTH-1:i];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_g     <= '0;
    end else begin
      if (in_ready) s1_valid <= in_valid;
      if (in_xfer)  s1_g     <= G;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      B         <= '0;
    end else if (s2_free) begin
      out_valid <= s1_valid;
      if (s1_valid) B <= dec;
    end
  end

`ifdef GRAY_STEP_CHECK_EN
  logic [WIDTH-1:0] prev_g;
  logic [WIDTH-1:0] diff;
  logic             have_prev;
  logic             step_err;
  logic             s1_err;
  logic             s2_err;
  logic [7:0]       cnt;

  // A legal step is a non-zero power of two difference; repeats are errors too.
  assign diff     = G ^ prev_g;
  assign step_err = have_prev &&
                    !((diff != '0) && ((diff & (diff - WIDTH'(1))) == '0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_g    <= '0;
      have_prev <= 1'b0;
      cnt       <= 8'd0;
      s1_err    <= 1'b0;
      s2_err    <= 1'b0;
    end else begin
      if (in_xfer) begin
        prev_g    <= G;
        have_prev <= 1'b1;
        s1_err    <= step_err;
        if (step_err && (cnt != 8'hFF)) cnt <= cnt + 8'd1;
      end
      if (s2_free && s1_valid) s2_err <= s1_err;
    end
  end

  assign out_err = s2_err;
  assign err_cnt = cnt;
`else
  assign out_err = 1'b0;
  assign err_cnt = 8'd0;
`endif

endmodule
`default_nettype wire

// File: doc/gray_to_bin_dec.md
# gray_to_bin_dec

Pipelined Gray-to-binary decoder that restores binary values from Gray-coded words produced by the team's binary-to-Gray converter. It accepts a stream of Gray codes over a valid/ready handshake, decodes them through a two-stage pipeline with backpressure, and optionally checks that consecutive accepted codes differ in exactly one bit. It sits on the receive side of any Gray-coded counter or pointer path.

## Interface
- `WIDTH`, default 4: code width in bits, 2..32.
- `clk`, input, 1: rising-edge clock.
- `rst_n`, input, 1: reset, **asynchronous, active-low**.
- `in_valid`, input, 1: `G` carries a code this cycle.
- `in_ready`, output, 1: decoder can accept a code this cycle.
- `G`, input, WIDTH: Gray-coded input word.
- `out_valid`, output, 1: `B` holds a decoded word.
- `out_ready`, input, 1: consumer accepts `B` this cycle.
- `B`, output, WIDTH: decoded binary word.
- `out_err`, output, 1: step error flag travelling with `B`. Present only with `GRAY_STEP_CHECK_EN`; otherwise tied 0.
- `err_cnt`, output, 8: saturating count of step errors. Present only with `GRAY_STEP_CHECK_EN`; otherwise tied 0.

## Operation
- Transfer rules:
  - An input transfer occurs when `in_valid && in_ready`.
  - An output transfer occurs when `out_valid && out_ready`.
- Stage 1 (S1) registers `G` and a valid bit.
- Stage 2 (S2) registers the decoded value, the error flag and a valid bit. S2 drives `B`, `out_err` and `out_valid`.
- Decode, computed between S1 and S2:
  - `B[WIDTH-1] = G[WIDTH-1]`.
  - `B[i] = B[i+1] ^ G[i]`, for i from WIDTH-2 down to 0.
  - Purely bitwise; no overflow or width extension.
- Flow control:
  - `s2_free = !out_valid || out_ready`.
  - S1 advances into S2 when `s1_valid && s2_free`.
  - `in_ready = !s1_valid || s2_free`. This is combinational, with no path from `in_valid`.
- Data held in either stage never changes while it is stalled. `B` is stable while `out_valid && !out_ready`.
- Simultaneous events:
  - Input and output transfers in the same cycle sustain one word per clock.
  - When S2 drains while S1 is empty, `out_valid` falls on the next edge.
- Reset behaviour:
  - Asserting `rst_n` low at any time clears both valid bits immediately and discards in-flight words.
  - Reset values: `out_valid=0`, `B=0`, `out_err=0`, `err_cnt=0`, `in_ready=1`.

## Timing
- Latency is 2 clocks. A code accepted at edge N appears on `B` with `out_valid=1` after edge N+1 and is visible in cycle N+1→N+2.
- Throughput is 1 word/clock while `out_ready=1`.
- Buffering is 2 words total. With `out_ready=0`, `in_ready` drops after two accepted words and stays low until S2 drains.
- `in_ready` reacts to `out_ready` in the same cycle.

## Configuration
- Macro `GRAY_STEP_CHECK_EN`.
- Defined, step checking is compiled in:
  - A `prev_G` register and a `have_prev` bit are updated on every input transfer. `have_prev` resets to 0.
  - A word is flagged with `err=1` when `have_prev=1` and `popcount(G ^ prev_G) != 1`. Repeated codes count as errors.
  - The flag follows its word through S1 and S2 and appears on `out_err`.
  - `err_cnt` increments by 1 at the input transfer of each flagged word and saturates at 255.
  - The first word after reset is never flagged.
- Undefined: no checker logic is built; `out_err` and `err_cnt` are constant 0. Decode and timing are identical in both builds.

## Test plan
- Full sweep: feed all 16 Gray codes in counting order (0000, 0001, 0011, … 1000) with `out_ready=1`. Required:
  - `B` reads 0000..1111 in order at one per clock, 2-cycle latency.
  - `G=0110` gives `B=0100`; `G=1000` gives `B=1111`.
  - Checker build: no `out_err`, `err_cnt=0`.
- Backpressure: hold `out_ready=0` and offer 3 codes. Required:
  - Exactly 2 are accepted, then `in_ready=0`.
  - `B` is held stable.
  - Releasing `out_ready` drains both words in order, followed by the third.
- Step error (checker build):
  - Send 0001 then 0010 (two bits differ). Required: second word has `out_err=1` and `err_cnt=1`.
  - Then send 0010 again (a repeat). Required: `err_cnt=2`.
- Saturation (checker build): send 300 alternating 0000/0011 codes. Required: `err_cnt` stops at 255.
- Mid-stream reset: drop `rst_n` asynchronously while both stages are full. Required:
  - `out_valid` goes to 0 immediately, with `B=0` and `err_cnt=0`.
  - The first word after release is not flagged.
- Random: random valid/ready toggling against a reference model of the decode. Required: no lost, duplicated or reordered words.
